// File: rtl/d_mem_pkg.sv
// Shared types and decode for the LEGv8 D-format load/store sequencer.
package d_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        MEM,
        WB
    } state_e;

    typedef enum logic [1:0] {
        FLT_NONE     = 2'b00,
        FLT_ILLEGAL  = 2'b01,
        FLT_MISALIGN = 2'b10,
        FLT_TIMEOUT  = 2'b11
    } fault_e;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    typedef struct packed {
        logic  legal;
        logic  load;
        logic  sgn;
        size_e size;
    } dec_t;

    localparam logic [10:0] OP_STURB  = 11'b00111000000;
    localparam logic [10:0] OP_LDURB  = 11'b00111000010;
    localparam logic [10:0] OP_STURH  = 11'b01111000000;
    localparam logic [10:0] OP_LDURH  = 11'b01111000010;
    localparam logic [10:0] OP_STURW  = 11'b10111000000;
    localparam logic [10:0] OP_LDURSW = 11'b10111000100;
    localparam logic [10:0] OP_STUR   = 11'b11111000000;
    localparam logic [10:0] OP_LDUR   = 11'b11111000010;

    // Rule-based decode; also accepts the zero-extending word load (op 10111000010).
    function automatic dec_t decode(input logic [10:0] op);
        dec_t d;
        d.size  = size_e'(op[10:9]);
        d.load  = op[1] | op[2];
        d.sgn   = op[2];
        d.legal = (op[8:3] == 6'b111000) && !op[0] && !(op[2] && op[1])
                  && !(op[2] && (op[10:9] != 2'b10));
        return d;
    endfunction

endpackage

// File: rtl/d_mem_lane.sv
// Byte-lane steering: store enables/data placement and load extraction/extension.
module d_mem_lane
    import d_mem_pkg::*;
(
    input  size_e       size,
    input  logic [2:0]  st_off,
    input  logic [63:0] st_data,
    output logic [7:0]  be,
    output logic [63:0] wdata,
    input  logic [2:0]  ld_off,
    input  logic [63:0] rdata,
    input  logic        sgn,
    output logic [63:0] ldata
);

    logic [7:0]  base_be;
    logic [63:0] shifted;

    // Store side: size-wide enable mask and data shifted into the addressed lane.
    always_comb begin
        case (size)
            SZ_B:    base_be = 8'h01;
            SZ_H:    base_be = 8'h03;
            SZ_W:    base_be = 8'h0F;
            default: base_be = 8'hFF;
        endcase
        be    = base_be << st_off;
        wdata = st_data << {st_off, 3'b000};
    end

    // Load side: bring the lane down to bit 0, then zero- or sign-extend.
    always_comb begin
        shifted = rdata >> {ld_off, 3'b000};
        case (size)
            SZ_B:    ldata = {56'b0, shifted[7:0]};
            SZ_H:    ldata = {48'b0, shifted[15:0]};
            SZ_W:    ldata = sgn ? {{32{shifted[31]}}, shifted[31:0]} : {32'b0, shifted[31:0]};
            default: ldata = shifted;
        endcase
    end

endmodule

// File: rtl/d_mem_sequencer.sv
// Multi-cycle LEGv8 D-format load/store sequencer (IDLE -> ADDR -> MEM -> WB).
// Optional feature: define D_MEM_ALIGN_CHECK_EN to fault misaligned accesses;
// otherwise the effective address is aligned down to the access size.
module d_mem_sequencer
    import d_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 64,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    output logic [4:0]        rf_sa,
    output logic [4:0]        rf_sb,
    input  logic [63:0]       rn_data,
    input  logic [63:0]       rt_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_be,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              rf_we,
    output logic [4:0]        rf_da,
    output logic [63:0]       rf_wdata,
    output logic              done,
    output logic [1:0]        fault
);

    localparam int unsigned TMO_W = $clog2(MEM_TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [10:0]        op_q, op_d;
    logic [8:0]         imm_q, imm_d;
    logic [63:0]        rn_q, rn_d;
    logic [63:0]        rt_q, rt_d;
    logic [2:0]         off_q, off_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [7:0]         mem_be_q, mem_be_d;
    logic [63:0]        mem_wdata_q, mem_wdata_d;
    logic               rf_we_q, rf_we_d;
    logic [4:0]         rf_da_q, rf_da_d;
    logic [63:0]        rf_wdata_q, rf_wdata_d;
    logic               done_q, done_d;
    fault_e             fault_q, fault_d;

    dec_t               dec;
    logic [63:0]        ea, ea_al;
    logic [2:0]         low_mask;
    logic [7:0]         lane_be;
    logic [63:0]        lane_wdata, lane_ldata;
    logic               unused_op2;

    assign dec         = decode(op_q);
    assign rf_sa       = instr[9:5];
    assign rf_sb       = instr[4:0];
    assign unused_op2  = ^instr[11:10];
    assign instr_ready = (state_q == IDLE);
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_be      = mem_be_q;
    assign mem_wdata   = mem_wdata_q;
    assign rf_we       = rf_we_q;
    assign rf_da       = rf_da_q;
    assign rf_wdata    = rf_wdata_q;
    assign done        = done_q;
    assign fault       = fault_q;

    // Effective address with signed 9-bit offset, plus its size-aligned form.
    always_comb begin
        ea = rn_q + {{55{imm_q[8]}}, imm_q};
        case (dec.size)
            SZ_B:    low_mask = 3'b000;
            SZ_H:    low_mask = 3'b001;
            SZ_W:    low_mask = 3'b011;
            default: low_mask = 3'b111;
        endcase
        ea_al = {ea[63:3], ea[2:0] & ~low_mask};
    end

    d_mem_lane u_lane (
        .size    (dec.size),
        .st_off  (ea_al[2:0]),
        .st_data (rt_q),
        .be      (lane_be),
        .wdata   (lane_wdata),
        .ld_off  (off_q),
        .rdata   (mem_rdata),
        .sgn     (dec.sgn),
        .ldata   (lane_ldata)
    );

    // Next-state and registered-output logic for the sequencer FSM.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        imm_d       = imm_q;
        rn_d        = rn_q;
        rt_d        = rt_q;
        off_d       = off_q;
        tmo_d       = tmo_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        rf_da_d     = rf_da_q;
        rf_wdata_d  = rf_wdata_q;
        rf_we_d     = 1'b0;
        done_d      = 1'b0;
        fault_d     = FLT_NONE;
        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    op_d    = instr[31:21];
                    imm_d   = instr[20:12];
                    rf_da_d = instr[4:0];
                    rn_d    = rn_data;
                    rt_d    = rt_data;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (!dec.legal) begin
                    fault_d = FLT_ILLEGAL;
                    done_d  = 1'b1;
                    state_d = WB;
                end
`ifdef D_MEM_ALIGN_CHECK_EN
                else if (|(ea[2:0] & low_mask)) begin
                    fault_d = FLT_MISALIGN;
                    done_d  = 1'b1;
                    state_d = WB;
                end
`endif
                else begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = !dec.load;
                    mem_addr_d  = ea_al[ADDR_W-1:0];
                    mem_be_d    = lane_be;
                    mem_wdata_d = lane_wdata;
                    off_d       = ea_al[2:0];
                    tmo_d       = '0;
                    state_d     = MEM;
                end
            end
            MEM: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    done_d    = 1'b1;
                    if (dec.load) begin
                        rf_wdata_d = lane_ldata;
                        rf_we_d    = (rf_da_q != 5'd31);
                    end
                    state_d = WB;
                end else if (tmo_q == TMO_W'(MEM_TIMEOUT - 1)) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    fault_d   = FLT_TIMEOUT;
                    done_d    = 1'b1;
                    state_d   = WB;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= '0;
            imm_q       <= '0;
            rn_q        <= '0;
            rt_q        <= '0;
            off_q       <= '0;
            tmo_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            rf_we_q     <= 1'b0;
            rf_da_q     <= '0;
            rf_wdata_q  <= '0;
            done_q      <= 1'b0;
            fault_q     <= FLT_NONE;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            imm_q       <= imm_d;
            rn_q        <= rn_d;
            rt_q        <= rt_d;
            off_q       <= off_d;
            tmo_q       <= tmo_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            rf_we_q     <= rf_we_d;
            rf_da_q     <= rf_da_d;
            rf_wdata_q  <= rf_wdata_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
        end
    end

endmodule
